// File: rtl/even_odd_pkg.sv
// Shared types and the key-folding helper for the even/odd range accumulator.
// The fold works on fixed maximum widths; callers zero-extend the key and truncate the result.
package even_odd_pkg;

    localparam int unsigned MAX_KEY_W  = 256;
    localparam int unsigned MAX_DATA_W = 64;
    localparam int unsigned FOLD_IDX_W = $clog2(MAX_DATA_W);

    typedef enum logic [1:0] {
        SUM_EVEN = 2'd0,
        SUM_ODD  = 2'd1,
        CNT_EVEN = 2'd2,
        CNT_ODD  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Key bit i lands on result bit (i mod data_w): XOR of data_w-wide slices, last slice zero-padded.
    function automatic logic [MAX_DATA_W-1:0] fold_key(input logic [MAX_KEY_W-1:0] key,
                                                       input int unsigned data_w);
        logic [MAX_DATA_W-1:0] folded;
        folded = '0;
        for (int unsigned i = 0; i < MAX_KEY_W; i++) begin
            folded[FOLD_IDX_W'(i % data_w)] ^= key[i];
        end
        return folded;
    endfunction

endpackage

// File: rtl/even_odd_key_lock.sv
// Combinational key check: zero mask for the golden key, otherwise the folded key difference.
module even_odd_key_lock
    import even_odd_pkg::*;
#(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       KEY_W      = 255,
    parameter logic [KEY_W-1:0]  GOLDEN_KEY = '0
) (
    input  logic [KEY_W-1:0]  working_key_i,
    output logic [DATA_W-1:0] mask_o
);

    logic                 key_ok;
    logic [MAX_KEY_W-1:0] diff_ext;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        diff_ext              = '0;
        diff_ext[KEY_W-1:0]   = working_key_i ^ GOLDEN_KEY;
    end

    assign key_ok = (working_key_i == GOLDEN_KEY);
    assign mask_o = key_ok ? '0 : DATA_W'(fold_key(diff_ext, DATA_W));

endmodule

// File: rtl/even_odd_range_acc.sv
// Iterative sum/count of the even or odd members of [s, e], one element per cycle,
// behind an ap_ctrl_hs handshake; the result is scrambled unless the golden key is applied.
module even_odd_range_acc
    import even_odd_pkg::*;
#(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       KEY_W      = 255,
    parameter logic [KEY_W-1:0]  GOLDEN_KEY = '0
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [DATA_W-1:0] s,
    input  logic [DATA_W-1:0] e,
    input  logic [1:0]        mode,
    input  logic [KEY_W-1:0]  working_key,
    output logic [DATA_W-1:0] ap_return
);

    logic [1:0]        rst_sync_q;
    logic              rst_int_n;

    state_t            state_q;
    logic [DATA_W-1:0] s_q;
    logic [DATA_W-1:0] e_q;
    mode_t             mode_q;
    logic [DATA_W:0]   cur_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] ret_q;
    logic              done_q;
    logic              idle_q;

    logic [DATA_W:0]   cur_start_d;
    logic [DATA_W:0]   cur_next_d;
    logic [DATA_W-1:0] acc_next_d;
    logic              in_range;
    logic [DATA_W-1:0] mask;

    even_odd_key_lock #(
        .DATA_W    (DATA_W),
        .KEY_W     (KEY_W),
        .GOLDEN_KEY(GOLDEN_KEY)
    ) u_key_lock (
        .working_key_i(working_key),
        .mask_o       (mask)
    );

    // Reset asserts asynchronously but releases two clocks later, in step with ap_clk.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // cur carries one extra bit so stepping past an all-ones end lands above e, never back at zero.
    always_comb begin
        cur_start_d = {1'b0, s_q} + {{DATA_W{1'b0}}, (s_q[0] != mode_q[0])};
        cur_next_d  = cur_q + (DATA_W+1)'(2);
        in_range    = (cur_q <= {1'b0, e_q});
        acc_next_d  = acc_q + (mode_q[1] ? DATA_W'(1) : cur_q[DATA_W-1:0]);
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ap_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            // NOTE: the datapath registers are reset too, so ap_return reads zero straight out of reset.
            state_q <= IDLE;
            s_q     <= '0;
            e_q     <= '0;
            mode_q  <= SUM_EVEN;
            cur_q   <= '0;
            acc_q   <= '0;
            ret_q   <= '0;
            done_q  <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (ap_start) begin
                        s_q     <= s;
                        e_q     <= e;
                        mode_q  <= mode_t'(mode);
                        idle_q  <= 1'b0;
                        state_q <= ALIGN;
                    end
                end
                ALIGN: begin
                    cur_q   <= cur_start_d;
                    acc_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    if (in_range) begin
                        acc_q <= acc_next_d;
                        cur_q <= cur_next_d;
                    end else begin
                        ret_q   <= acc_q ^ mask;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    idle_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ap_done   = done_q;
    assign ap_ready  = done_q;
    assign ap_idle   = idle_q;
    assign ap_return = ret_q;

endmodule

// File: doc/even_odd_range_acc.md
Name: even_odd_range_acc

Overview:
- Parametrised, key-locked successor to the even/odd block.
- Over the unsigned inclusive range [s, e], it sums or counts the even or odd members.
- Generalised in data width, key width and operating mode; iterative with one element per cycle.
- Uses the HLS ap_ctrl_hs block-level handshake, so it drops into the same HLS-style top levels.
- Output is scrambled unless the correct working key is applied.

Parameters:
- DATA_W, 32, width of s, e, accumulator and ap_return.
- KEY_W, 255, width of working_key.
- GOLDEN_KEY, KEY_W'b0, unlocking key; set per instance at integration.

Ports:
- ap_clk  in  1  single clock, rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- ap_start  in  1  start request, sampled only in IDLE.
- ap_done  out  1  one-cycle pulse, result valid.
- ap_idle  out  1  high while in IDLE.
- ap_ready  out  1  one-cycle pulse, coincident with ap_done.
- s  in  DATA_W  range start, unsigned.
- e  in  DATA_W  range end, unsigned, inclusive.
- mode  in  2  0=sum evens, 1=sum odds, 2=count evens, 3=count odds.
- working_key  in  KEY_W  lock key; expected static.
- ap_return  out  DATA_W  result, held until the next job's DONE.

Behaviour:
- Reset (async assert, sync deassert internally):
  - state=IDLE, ap_idle=1, ap_done=0, ap_ready=0, ap_return=0, acc=0.
- States: IDLE, ALIGN, RUN, DONE.
- IDLE:
  - ap_idle=1.
  - On ap_start=1: latch s, e, mode into s_q, e_q, mode_q → ALIGN.
  - s, e and mode are don't-care after the latch cycle.
- ALIGN:
  - cur = s_q + (s_q[0] != mode_q[0]); cur is DATA_W+1 bits so a carry out of s_q=all-ones is preserved.
  - acc=0 → RUN.
- RUN, each cycle:
  - If cur <= {1'b0,e_q}: acc += (mode_q[1] ? 1 : cur[DATA_W-1:0]); cur += 2.
  - Else → DONE.
  - cur must never wrap: use DATA_W+1 bits, and a carry-out terminates the loop.
- DONE:
  - ap_return ← acc XOR mask; ap_done=ap_ready=1 for exactly this cycle → IDLE.
- Latency: start accepted at cycle t gives ap_done at t+3+N, where N = number of matching elements.
  - Empty range (s>e, or no element of the selected parity): N=0, latency 3, result 0 before masking.
- Arithmetic: acc wraps modulo 2^DATA_W with no saturation and no overflow flag.
- ap_start while not IDLE is ignored (no queuing).
- ap_start held high continuously: a new job starts in the IDLE cycle following DONE. Back-to-back throughput is one job per N+4 cycles.
- Lock:
  - key_ok = (working_key == GOLDEN_KEY).
  - mask = key_ok ? 0 : fold of working_key XOR GOLDEN_KEY into DATA_W bits (XOR of DATA_W-wide slices, last slice zero-padded).
  - Handshake timing is identical whether locked or unlocked; only the data differs.
- Reset mid-operation: immediate return to IDLE with outputs at reset values; the partial result is discarded.
- ap_return is stable outside DONE and updates only on the DONE cycle.

Decomposition:
- Package even_odd_pkg:
  - mode_t enum (SUM_EVEN, SUM_ODD, CNT_EVEN, CNT_ODD).
  - state_t enum (IDLE, ALIGN, RUN, DONE).
  - Function fold_key(KEY_W→DATA_W).
- Sub-module even_odd_key_lock: combinational key compare plus mask generation, instantiated once.
- FSM and datapath live in the top.

Test Plan:
- Unlocked (working_key=GOLDEN_KEY), DATA_W=32, s=0, e=10, mode=0 → ap_return=30; ap_done and ap_ready pulse together at t+9 (N=6); ap_idle low from t+1 to t+9.
- Unlocked, s=3, e=9, mode=3 → ap_return=4 at t+7; then mode=1 on the same range → 24.
- Unlocked, s=9, e=2, any mode → ap_return=0 at t+3. Also s=e=5, mode=0 → 0 at t+3.
- DATA_W=8, s=250, e=255, mode=1 → 251+253+255 = 759 mod 256 = 247; the loop terminates (no wrap hang); done at t+6.
- Locked: working_key=GOLDEN_KEY^1, s=0, e=10, mode=0 → ap_return=30^1=31 with identical timing to the unlocked run.
- Reset pulsed during RUN of s=0, e=1000 → outputs return to 0/idle=1 asynchronously. A subsequent job with s=0, e=4, mode=2 returns 3.
- ap_start held high through 3 jobs → exactly 3 done pulses; mid-job changes to s/e do not alter results.
